// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b pipeline instruction fetch.
//   Owns the PC and runs the read/resp handshake with instruction memory.
//   Presents one instruction per cycle on if_*, together with its PC, PC+2
//   and the control-ROM fields (opcode, imm bit, jsr bit). A one-entry hold
//   buffer absorbs a response that arrives while decode is stalled. A redirect
//   flushes in-flight work. If a request is still outstanding, its response is
//   drained and discarded before fetching at the new PC.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_address/imem_read     fetch request (address stable until imem_resp)
//   imem_rdata/imem_resp       memory response
//   stall                      decode cannot accept; if_* hold
//   redirect/redirect_pc       taken branch/jump target (bit 0 forced to 0)
//   if_valid/if_ir/if_pc/if_npc/if_opcode/if_imm/if_jsr   registered outputs
// Optional macro FETCH_STATS_EN adds the stat_delivered and stat_redirects
// counters. Both wrap modulo 2^16.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [15:0] if_npc,
  output logic [3:0]  if_opcode,
  output logic        if_imm,
  output logic        if_jsr
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_delivered,
  output logic [15:0] stat_redirects
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] drain_addr_q;   // address of the request being drained
  logic        out_valid_q;
  logic [15:0] out_ir_q;
  logic [15:0] out_pc_q;
  logic [15:0] out_npc_q;
  logic [15:0] hold_ir_q;
  logic [15:0] hold_pc_q;

  // In DRAIN, pc_q already holds the redirect target. The bus keeps the old
  // address until the outstanding response arrives.
  assign imem_read    = rst_n & ((state_q == S_FETCH) | (state_q == S_DRAIN));
  assign imem_address = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign if_valid  = out_valid_q;
  assign if_ir     = out_ir_q;
  assign if_pc     = out_pc_q;
  assign if_npc    = out_npc_q;
  assign if_opcode = out_ir_q[15:12];
  assign if_imm    = out_ir_q[5];
  assign if_jsr    = out_ir_q[11];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_valid_q  <= 1'b0;
      out_ir_q     <= '0;
      out_pc_q     <= '0;
      out_npc_q    <= '0;
      hold_ir_q    <= '0;
      hold_pc_q    <= '0;
    end else begin
      // Consumed with nothing new loaded: emit a bubble.
      if (out_valid_q && !stall) out_valid_q <= 1'b0;

      if (redirect) begin
        out_valid_q <= 1'b0;
        hold_ir_q   <= '0;
        hold_pc_q   <= '0;
        pc_q        <= redirect_pc & 16'hFFFE;
        case (state_q)
          S_FETCH: begin
            if (!imem_resp) begin
              state_q      <= S_DRAIN;
              drain_addr_q <= pc_q;
            end
          end
          S_HOLD:  state_q <= S_FETCH;
          // A response that coincides with the redirect completes the drain.
          S_DRAIN: if (imem_resp) state_q <= S_FETCH;
          default: state_q <= S_FETCH;
        endcase
      end else begin
        case (state_q)
          S_FETCH: begin
            if (imem_resp) begin
              pc_q <= pc_q + 16'd2;
              if (!out_valid_q || !stall) begin
                out_valid_q <= 1'b1;
                out_ir_q    <= imem_rdata;
                out_pc_q    <= pc_q;
                out_npc_q   <= pc_q + 16'd2;
              end else begin
                hold_ir_q <= imem_rdata;
                hold_pc_q <= pc_q;
                state_q   <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              out_valid_q <= 1'b1;
              out_ir_q    <= hold_ir_q;
              out_pc_q    <= hold_pc_q;
              out_npc_q   <= hold_pc_q + 16'd2;
              state_q     <= S_FETCH;
            end
          end
          S_DRAIN: if (imem_resp) state_q <= S_FETCH;
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stat_delivered_q;
  logic [15:0] stat_redirects_q;

  assign stat_delivered = stat_delivered_q;
  assign stat_redirects = stat_redirects_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_delivered_q <= '0;
      stat_redirects_q <= '0;
    end else begin
      if (out_valid_q && !stall) stat_delivered_q <= stat_delivered_q + 16'd1;
      if (redirect)              stat_redirects_q <= stat_redirects_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: testbench for fetch_stage. It runs directed scenarios and
// then a randomized run against a program-order reference of the
// instruction stream.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [15:0] imem_address, w_imem_address;
  logic        imem_read, w_imem_read;
  logic        if_valid, w_if_valid;
  logic [15:0] if_ir, if_pc, if_npc, w_if_ir, w_if_pc, w_if_npc;
  logic [3:0]  if_opcode, w_if_opcode;
  logic        if_imm, if_jsr, w_if_imm, w_if_jsr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .if_npc(if_npc),
    .if_opcode(if_opcode), .if_imm(if_imm), .if_jsr(if_jsr)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_address(w_imem_address), .imem_read(w_imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(w_if_valid), .if_ir(w_if_ir), .if_pc(w_if_pc), .if_npc(w_if_npc),
    .if_opcode(w_if_opcode), .if_imm(w_if_imm), .if_jsr(w_if_jsr)
  );

  // Memory contents: an odd multiplier makes the address-to-word map a
  // bijection, so every address holds a distinct word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (imem_read !== 1'b0) begin
        bad++; $display("FAIL reset_read cyc=%0d got=%b exp=0", i, imem_read);
      end
    end
    total++;
    if ({if_valid, if_ir, if_pc, if_npc} !== 49'd0) begin
      bad++; $display("FAIL reset_outs got=%b/%h/%h/%h exp=0", if_valid, if_ir, if_pc, if_npc);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
      bad++; $display("FAIL reset_first_fetch got read=%b addr=%h exp read=1 addr=0000", imem_read, imem_address);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", if_valid);
    end
  endtask

  task automatic test_stream();
    logic [15:0] w;
    w = 16'h1261;
    imem_resp = 1'b1; imem_rdata = w;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_npc !== 16'h0002 || if_ir !== w) begin
      bad++; $display("FAIL stream0 got v=%b pc=%h npc=%h ir=%h exp v=1 pc=0000 npc=0002 ir=%h", if_valid, if_pc, if_npc, if_ir, w);
    end
    total++;
    if (if_opcode !== 4'h1 || if_imm !== w[5] || if_jsr !== w[11]) begin
      bad++; $display("FAIL stream0_fields got op=%h imm=%b jsr=%b exp op=1 imm=%b jsr=%b", if_opcode, if_imm, if_jsr, w[5], w[11]);
    end
    w = 16'h5AA0;
    imem_rdata = w;
    step();
    imem_resp = 1'b0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_npc !== 16'h0004 || if_ir !== w) begin
      bad++; $display("FAIL stream1 got v=%b pc=%h npc=%h ir=%h exp v=1 pc=0002 npc=0004 ir=%h", if_valid, if_pc, if_npc, if_ir, w);
    end
    total++;
    if (if_opcode !== 4'h5 || if_imm !== w[5] || if_jsr !== w[11]) begin
      bad++; $display("FAIL stream1_fields got op=%h imm=%b jsr=%b exp op=5 imm=%b jsr=%b", if_opcode, if_imm, if_jsr, w[5], w[11]);
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'h0E25;
    step();
    imem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_ir !== 16'h5AA0 || imem_read !== 1'b0) begin
        bad++; $display("FAIL stall_hold cyc=%0d got v=%b pc=%h ir=%h read=%b exp v=1 pc=0002 ir=5aa0 read=0", i, if_valid, if_pc, if_ir, imem_read);
      end
      if (i < 3) step();
    end
    stall = 1'b0;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0004 || if_npc !== 16'h0006 || if_ir !== 16'h0E25) begin
      bad++; $display("FAIL stall_release got v=%b pc=%h npc=%h ir=%h exp v=1 pc=0004 npc=0006 ir=0e25", if_valid, if_pc, if_npc, if_ir);
    end
    total++;
    if (imem_read !== 1'b1 || imem_address !== 16'h0006) begin
      bad++; $display("FAIL stall_next_addr got read=%b addr=%h exp read=1 addr=0006", imem_read, imem_address);
    end
  endtask

  task automatic test_redirect_mid();
    step();
    total++;
    if (if_valid !== 1'b0 || imem_address !== 16'h0006) begin
      bad++; $display("FAIL bubble got v=%b addr=%h exp v=0 addr=0006", if_valid, imem_address);
    end
    redirect = 1'b1; redirect_pc = 16'h3001;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_read !== 1'b1 || imem_address !== 16'h0006 || if_valid !== 1'b0) begin
        bad++; $display("FAIL drain_hold cyc=%0d got read=%b addr=%h v=%b exp read=1 addr=0006 v=0", i, imem_read, imem_address, if_valid);
      end
      if (i < 2) step();
    end
    imem_resp = 1'b1; imem_rdata = 16'hDEAD;
    step();
    imem_resp = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 16'h3000) begin
      bad++; $display("FAIL drain_done got v=%b read=%b addr=%h exp v=0 read=1 addr=3000", if_valid, imem_read, imem_address);
    end
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL drain_dropped got v=%b ir=%h exp v=0", if_valid, if_ir);
    end
  endtask

  task automatic test_redirect_resp_stall();
    imem_resp = 1'b1; imem_rdata = 16'h2345;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h3000 || if_ir !== 16'h2345) begin
      bad++; $display("FAIL rrs_setup got v=%b pc=%h ir=%h exp v=1 pc=3000 ir=2345", if_valid, if_pc, if_ir);
    end
    redirect = 1'b1; redirect_pc = 16'h3000; stall = 1'b1; imem_rdata = 16'hBEEF;
    step();
    redirect = 1'b0; stall = 1'b0; imem_resp = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 16'h3000) begin
      bad++; $display("FAIL rrs_flush got v=%b read=%b addr=%h exp v=0 read=1 addr=3000", if_valid, imem_read, imem_address);
    end
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL rrs_no_data got v=%b ir=%h exp v=0", if_valid, if_ir);
    end
    imem_resp = 1'b1; imem_rdata = 16'h1111;
    step();
    imem_resp = 1'b0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h3000 || if_ir !== 16'h1111) begin
      bad++; $display("FAIL rrs_refetch got v=%b pc=%h ir=%h exp v=1 pc=3000 ir=1111", if_valid, if_pc, if_ir);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; imem_resp = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    total++;
    if (w_imem_read !== 1'b1 || w_imem_address !== 16'hFFFE) begin
      bad++; $display("FAIL wrap_first got read=%b addr=%h exp read=1 addr=fffe", w_imem_read, w_imem_address);
    end
    imem_resp = 1'b1; imem_rdata = 16'h1234;
    step();
    imem_resp = 1'b0;
    total++;
    if (w_if_valid !== 1'b1 || w_if_pc !== 16'hFFFE || w_if_npc !== 16'h0000) begin
      bad++; $display("FAIL wrap_npc got v=%b pc=%h npc=%h exp v=1 pc=fffe npc=0000", w_if_valid, w_if_pc, w_if_npc);
    end
    total++;
    if (w_imem_address !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr got=%h exp=0000", w_imem_address);
    end
  endtask

  // Randomized run: memory with 0..2 cycles of latency, random stalls and
  // redirects. Instructions accepted by decode must follow program order from
  // the last redirect target, and each must carry the word stored at its address.
  task automatic test_random();
    logic [15:0] exp_pc, req_addr, ew;
    logic [15:0] snap_ir, snap_pc, snap_npc;
    logic        busy, hold_pending, flush_pending;
    int unsigned lat;
    int          delivered;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_pc = 16'h0000; busy = 1'b0; lat = 0; req_addr = '0;
    hold_pending = 1'b0; flush_pending = 1'b0; delivered = 0;
    snap_ir = '0; snap_pc = '0; snap_npc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_pending) begin
        total++;
        if (if_valid !== 1'b1 || if_ir !== snap_ir || if_pc !== snap_pc || if_npc !== snap_npc) begin
          bad++; $display("FAIL rnd_stall_hold cyc=%0d got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h", cyc, if_valid, if_pc, if_ir, snap_pc, snap_ir);
        end
      end
      if (flush_pending) begin
        total++;
        if (if_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_flush cyc=%0d got v=%b exp v=0", cyc, if_valid);
        end
      end

      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = 16'($urandom);

      imem_resp  = 1'b0;
      imem_rdata = 16'($urandom);
      if (imem_read) begin
        if (!busy) begin
          busy = 1'b1; req_addr = imem_address; lat = $urandom_range(0, 2);
        end else begin
          total++;
          if (imem_address !== req_addr) begin
            bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, imem_address, req_addr);
          end
        end
        if (lat == 0) begin
          imem_resp = 1'b1; imem_rdata = mem_word(req_addr); busy = 1'b0;
        end else begin
          lat--;
        end
      end else if (busy) begin
        total++; bad++;
        $display("FAIL rnd_read_dropped cyc=%0d got read=0 exp read=1 addr=%h", cyc, req_addr);
        busy = 1'b0;
      end

      hold_pending  = 1'b0;
      flush_pending = redirect;
      if (redirect) begin
        exp_pc = redirect_pc & 16'hFFFE;
      end else if (if_valid && !stall) begin
        ew = mem_word(exp_pc);
        total++;
        if (if_pc !== exp_pc || if_ir !== ew || if_npc !== 16'(exp_pc + 16'd2)) begin
          bad++; $display("FAIL rnd_deliver cyc=%0d got pc=%h ir=%h npc=%h exp pc=%h ir=%h npc=%h", cyc, if_pc, if_ir, if_npc, exp_pc, ew, 16'(exp_pc + 16'd2));
        end
        total++;
        if (if_opcode !== ew[15:12] || if_imm !== ew[5] || if_jsr !== ew[11]) begin
          bad++; $display("FAIL rnd_fields cyc=%0d got op=%h imm=%b jsr=%b exp op=%h imm=%b jsr=%b", cyc, if_opcode, if_imm, if_jsr, ew[15:12], ew[5], ew[11]);
        end
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end else if (if_valid && stall) begin
        hold_pending = 1'b1;
        snap_ir = if_ir; snap_pc = if_pc; snap_npc = if_npc;
      end
      step();
    end
    redirect = 1'b0; stall = 1'b0; imem_resp = 1'b0;
    total++;
    if (delivered < 200) begin
      bad++; $display("FAIL rnd_progress got=%0d exp>=200", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_mid();
    test_redirect_resp_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
